stopwatch_bcd_core: RTL and testbench
=====================================

STOPWATCH_BCD_CORE -- requirements
Module: stopwatch_bcd_core

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth applied to slow_clk and start_stop (min 2).
REQ-002 SHALL have parameter MAX_TENS_SEC, default 5, the largest tens-of-seconds digit before wrap (range 1..9).
REQ-003 SHALL have port clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port slow_clk  input  1  0.01 s square wave from the upstream divider, treated as data, never as a clock.
REQ-006 SHALL have port start_stop  input  1  debounced button level; each rising edge requests run/pause toggle.
REQ-007 SHALL have port clear  input  1  level; returns the count to 00.00 and stops.
REQ-008 SHALL have port digit3..digit0  output  4 each  BCD tens-sec, units-sec, tenths, hundredths.
REQ-009 SHALL have port running  output  1  high while state is RUN.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on 59.99 -> 00.00 rollover.

Function
REQ-011 SHALL pass slow_clk and start_stop each through a SYNC_STAGES flop synchronizer followed by a rising-edge detector, yielding one-clk pulses tick and btn.
REQ-012 SHALL assert tick exactly once per slow_clk rising edge, SYNC_STAGES+1 clk cycles after that edge; no tick on falling edges.
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE: IDLE->RUN on btn; RUN->PAUSE on btn; PAUSE->RUN on btn; any state->IDLE when clear high.
REQ-014 SHALL advance the BCD count by one hundredth on tick only while the registered state is RUN (state before any same-cycle transition).
REQ-015 SHALL carry digit0 9->0 into digit1, digit1 9->0 into digit2, digit2 9->0 into digit3; digit3 MAX_TENS_SEC with lower digits all 9 wraps the whole count to 0.
REQ-016 SHALL pulse wrap for exactly the cycle after the wrapping tick, concurrent with digits reading 00.00.
REQ-017 SHALL give clear priority over tick and btn in the same cycle: next cycle digits 0, state IDLE, wrap 0.
REQ-018 SHALL ignore btn while clear is high; a start_stop edge held through clear is not replayed afterward.
REQ-019 SHALL, on simultaneous tick and btn in RUN, count that tick and then enter PAUSE; in PAUSE, not count that tick and then enter RUN.
REQ-020 SHALL keep every digit in 0..9 (digit3 in 0..MAX_TENS_SEC) at all times; no illegal BCD codes reach outputs.
REQ-021 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-022 SHALL, when reset is low at a clk edge, set state IDLE, digits 0, running 0, wrap 0, synchronizer and edge-detector flops 0.
REQ-023 SHALL, when reset is applied mid-count, discard the count with no wrap pulse; a slow_clk already high at reset release yields no tick until its next rising edge.

Configuration
REQ-024 SHALL support macro STOPWATCH_LAP_HOLD_EN; when defined, add input lap (1 bit, synchronized and edge-detected like start_stop) whose each rising edge in RUN toggles a frozen display while the internal count continues.
REQ-025 SHALL, with STOPWATCH_LAP_HOLD_EN defined, release any freeze on entering PAUSE or IDLE and on clear; when undefined, no lap port exists and digits always show the live count.

Structure
REQ-026 SHALL place the state enum (IDLE/RUN/PAUSE), BCD width 4, and digit max constants in shared package stopwatch_pkg.
REQ-027 SHALL instantiate sub-module sync_edge_det (parameterized synchronizer plus rising-edge pulse) once per async input.

Verification
REQ-028 SHALL check: reset low 2 cycles, slow_clk toggling -> digits 00.00, running 0, no tick counted.
REQ-029 SHALL check: btn then 123 slow_clk rising edges -> digits 01.23, running 1; each increment lands SYNC_STAGES+1 clk after its edge.
REQ-030 SHALL check: preload 59.99 via ticks, one more edge -> 00.00 with wrap high exactly 1 cycle.
REQ-031 SHALL check: at 00.50 pulse start_stop, apply 10 edges -> remains 00.50, running 0; second press resumes at 00.51 on next edge.
REQ-032 SHALL check: clear asserted same cycle as tick and btn at 12.34 -> next cycle 00.00, IDLE, wrap 0.
REQ-033 SHALL check (STOPWATCH_LAP_HOLD_EN): lap at 03.00, 200 edges -> display 03.00; second lap -> 05.00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: run-state enum, BCD
// digit width/limits, and a single-digit BCD increment helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int                BCD_W            = 4;
  localparam int                NUM_DIGITS       = 4;
  localparam logic [BCD_W-1:0]  DIGIT_MAX        = 4'd9;
  localparam int                TENS_MAX_DEFAULT = 5;

  // Returns {carry, next_digit}; any code at or above d_max rolls to 0 so an
  // out-of-range value can never persist.
  function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] d,
                                             input logic [BCD_W-1:0] d_max);
    logic [BCD_W:0] res;
    if (d >= d_max) res = {1'b1, {BCD_W{1'b0}}};
    else            res = {1'b0, d + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by a rising-edge detector producing a
// one-clock pulse; stays quiet until the input has been seen low after reset.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_valid;
  logic              r_prev;
  logic              r_armed;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  // r_valid tracks pipeline fill so an input already high at reset release is
  // never mistaken for a rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '0;
      r_valid <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_async};
      r_valid <= {r_valid[STAGES-2:0], 1'b1};
      r_prev  <= w_level;
      r_armed <= r_armed | (r_valid[STAGES-1] & ~w_level);
    end
  end

  assign o_pulse = r_armed & w_level & ~r_prev;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// BCD stopwatch core: synchronized 0.01 s tick and start/stop button, IDLE/RUN/PAUSE
// control, 4-digit BCD count. Optional lap freeze under STOPWATCH_LAP_HOLD_EN.
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_TENS_SEC = TENS_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             start_stop,
  input  logic             clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic             lap,
`endif
  output logic [BCD_W-1:0] digit3,
  output logic [BCD_W-1:0] digit2,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit0,
  output logic             running,
  output logic             wrap
);

  localparam logic [BCD_W-1:0] TENS_MAX = BCD_W'(MAX_TENS_SEC);

  state_e                               r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]     r_cnt, w_cnt_nxt, w_disp;
  logic                                 r_running, r_wrap, w_wrap_nxt;
  logic                                 w_tick, w_btn;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_tick (
    .clk(clk), .reset(reset), .i_async(slow_clk), .o_pulse(w_tick)
  );
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_btn (
    .clk(clk), .reset(reset), .i_async(start_stop), .o_pulse(w_btn)
  );

  // Next-state logic; clear overrides and swallows any same-cycle button edge.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else if (w_btn) begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Ripple-carry BCD increment gated by the pre-transition state.
  always_comb begin
    logic w_carry;
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    w_carry    = 1'b0;
    if (clear) begin
      w_cnt_nxt = '0;
    end else if (w_tick && (r_state == ST_RUN)) begin
      w_carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_carry) begin
          {w_carry, w_cnt_nxt[i]} = bcd_inc(r_cnt[i], (i == NUM_DIGITS-1) ? TENS_MAX : DIGIT_MAX);
        end else begin
          w_cnt_nxt[i] = r_cnt[i];
        end
      end
      w_wrap_nxt = w_carry;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State, count and status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_wrap    <= w_wrap_nxt;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic                             w_lap, w_frozen_nxt;
  logic                             r_frozen;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] r_disp;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_lap (
    .clk(clk), .reset(reset), .i_async(lap), .o_pulse(w_lap)
  );

  // Freeze toggles only in RUN and drops whenever RUN is left.
  always_comb begin
    w_frozen_nxt = (w_state_nxt == ST_RUN) &&
                   (r_frozen ^ (w_lap && (r_state == ST_RUN) && !clear));
  end

  // Display register: tracks the live count unless frozen.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frozen <= 1'b0;
      r_disp   <= '0;
    end else begin
      r_frozen <= w_frozen_nxt;
      if (!w_frozen_nxt) r_disp <= w_cnt_nxt;
      else               r_disp <= r_disp;
    end
  end

  assign w_disp = r_disp;
`else
  assign w_disp = r_cnt;
`endif

  assign digit3  = w_disp[3];
  assign digit2  = w_disp[2];
  assign digit1  = w_disp[1];
  assign digit0  = w_disp[0];
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core: vector table, hand-written corner
// sequences and randomized operations against a hundredths-count reference model.
module tb_stopwatch_bcd_core;

  localparam int SS   = 2;
  localparam int MAXT = 5;
  localparam int MOD  = (MAXT + 1) * 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       slow_clk = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       running, wrap;

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_seen = 0;

  // reference model: count in hundredths, run flag, lap freeze
  int m_cnt = 0;
  bit m_run = 1'b0;
  int m_wraps = 0;
  bit m_frozen = 1'b0;
  int m_disp = 0;

  stopwatch_bcd_core #(.SYNC_STAGES(SS), .MAX_TENS_SEC(MAXT)) dut (
    .clk(clk), .reset(reset), .slow_clk(slow_clk), .start_stop(start_stop),
    .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap) wrap_seen = wrap_seen + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_TICK, OP_BTN, OP_CLR} op_e;
  typedef struct {
    op_e op;
    int  n;
    int  exp_cnt;
    bit  exp_run;
  } vec_t;
  vec_t vecs[15];

  function automatic int shown();
    return int'(digit3) * 1000 + int'(digit2) * 100 + int'(digit1) * 10 + int'(digit0);
  endfunction

  function automatic int exp_disp();
    return m_frozen ? m_disp : m_cnt;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    int e;
    @(negedge clk);
    e = exp_disp();
    chk({name, ".d0"}, int'(digit0), e % 10);
    chk({name, ".d1"}, int'(digit1), (e / 10) % 10);
    chk({name, ".d2"}, int'(digit2), (e / 100) % 10);
    chk({name, ".d3"}, int'(digit3), e / 1000);
    chk({name, ".running"}, int'(running), int'(m_run));
  endtask

  task automatic m_tick();
    if (m_run) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == MOD) begin
        m_cnt = 0;
        m_wraps++;
      end
    end
  endtask

  task automatic m_press();
    m_run = !m_run;
    if (!m_run) m_frozen = 1'b0;
  endtask

  task automatic m_clear();
    m_cnt = 0;
    m_run = 1'b0;
    m_frozen = 1'b0;
  endtask

  task automatic do_tick();
    @(posedge clk); #1 slow_clk = 1'b1;
    repeat (SS) @(posedge clk);
    #1 slow_clk = 1'b0;
    repeat (SS) @(posedge clk);
    m_tick();
  endtask

  task automatic do_press();
    @(posedge clk); #1 start_stop = 1'b1;
    repeat (SS) @(posedge clk);
    #1 start_stop = 1'b0;
    repeat (SS) @(posedge clk);
    m_press();
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    repeat (2) @(posedge clk);
    m_clear();
  endtask

`ifdef STOPWATCH_LAP_HOLD_EN
  task automatic do_lap();
    @(posedge clk); #1 lap = 1'b1;
    repeat (SS) @(posedge clk);
    #1 lap = 1'b0;
    repeat (SS) @(posedge clk);
    if (m_run) begin
      m_frozen = !m_frozen;
      if (m_frozen) m_disp = m_cnt;
    end
  endtask
`endif

  initial begin
    int old_cnt;
    int r;

    vecs[0]  = '{OP_TICK, 5,   0,   1'b0};
    vecs[1]  = '{OP_BTN,  1,   0,   1'b1};
    vecs[2]  = '{OP_TICK, 123, 123, 1'b1};
    vecs[3]  = '{OP_BTN,  1,   123, 1'b0};
    vecs[4]  = '{OP_TICK, 10,  123, 1'b0};
    vecs[5]  = '{OP_BTN,  1,   123, 1'b1};
    vecs[6]  = '{OP_TICK, 1,   124, 1'b1};
    vecs[7]  = '{OP_CLR,  1,   0,   1'b0};
    vecs[8]  = '{OP_BTN,  1,   0,   1'b1};
    vecs[9]  = '{OP_TICK, 50,  50,  1'b1};
    vecs[10] = '{OP_BTN,  1,   50,  1'b0};
    vecs[11] = '{OP_TICK, 10,  50,  1'b0};
    vecs[12] = '{OP_BTN,  1,   50,  1'b1};
    vecs[13] = '{OP_TICK, 1,   51,  1'b1};
    vecs[14] = '{OP_CLR,  1,   0,   1'b0};

    // reset held with slow_clk toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 slow_clk = ~slow_clk;
    end
    @(negedge clk);
    chk("reset.digits", shown(), 0);
    chk("reset.running", int'(running), 0);
    chk("reset.wrap", int'(wrap), 0);
    @(posedge clk); #1 slow_clk = 1'b0; reset = 1'b1;
    repeat (6) @(posedge clk);
    check_state("post_reset");

    // table-driven vectors
    for (int v = 0; v < 15; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        case (vecs[v].op)
          OP_TICK: do_tick();
          OP_BTN:  do_press();
          default: do_clear();
        endcase
      end
      @(negedge clk);
      chk($sformatf("vec%0d.count", v), shown(), vecs[v].exp_cnt);
      chk($sformatf("vec%0d.running", v), int'(running), int'(vecs[v].exp_run));
    end

    // tick latency: increment lands SS+1 edges after slow_clk rises
    do_press();
    old_cnt = m_cnt;
    @(posedge clk); #1 slow_clk = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("latency.edge%0d", k), shown(), (k <= SS) ? old_cnt : old_cnt + 1);
    end
    slow_clk = 1'b0;
    repeat (SS + 1) @(posedge clk);
    m_tick();
    check_state("latency.after");

    // simultaneous tick and button, in RUN then in PAUSE
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1 slow_clk = 1'b1; start_stop = 1'b1;
      repeat (SS) @(posedge clk);
      #1 slow_clk = 1'b0; start_stop = 1'b0;
      repeat (SS) @(posedge clk);
      m_tick();
      m_press();
      check_state($sformatf("tick_btn%0d", j));
    end

    // wrap from the top count
    do_clear();
    do_press();
    for (int k = 0; k < MOD - 1; k++) do_tick();
    check_state("pre_wrap");
    @(posedge clk); #1 slow_clk = 1'b1;
    for (int k = 1; k <= SS + 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("wrap.edge%0d", k), int'(wrap), (k == SS + 1) ? 1 : 0);
      if (k == SS + 1) chk("wrap.digits", shown(), 0);
      if (k == SS) chk("wrap.before", shown(), MOD - 1);
    end
    slow_clk = 1'b0;
    repeat (SS + 1) @(posedge clk);
    m_tick();
    check_state("post_wrap");

    // clear colliding with tick and button at 12.34
    do_clear();
    do_press();
    for (int k = 0; k < 1234; k++) do_tick();
    check_state("at_1234");
    @(posedge clk); #1 slow_clk = 1'b1; start_stop = 1'b1;
    repeat (SS) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("collide.digits", shown(), 0);
    chk("collide.running", int'(running), 0);
    chk("collide.wrap", int'(wrap), 0);
    clear = 1'b0; slow_clk = 1'b0; start_stop = 1'b0;
    m_clear();
    repeat (8) @(posedge clk);
    check_state("collide.no_replay");

    // reset mid-count with slow_clk high across release
    do_press();
    for (int k = 0; k < 7; k++) do_tick();
    @(posedge clk); #1 slow_clk = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_clear();
    repeat (6) @(posedge clk);
    check_state("midreset");
    do_press();
    repeat (6) @(posedge clk);
    check_state("midreset.held_high");
    #1 slow_clk = 1'b0;
    repeat (SS + 2) @(posedge clk);
    do_tick();
    check_state("midreset.next_edge");

`ifdef STOPWATCH_LAP_HOLD_EN
    do_clear();
    do_press();
    for (int k = 0; k < 300; k++) do_tick();
    do_lap();
    for (int k = 0; k < 200; k++) do_tick();
    @(negedge clk);
    chk("lap.frozen", shown(), 300);
    do_lap();
    @(negedge clk);
    chk("lap.released", shown(), 500);
    check_state("lap.model");
`endif

    // randomized operations against the model
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75) do_tick();
      else if (r < 85) do_press();
`ifdef STOPWATCH_LAP_HOLD_EN
      else if (r < 95) do_lap();
`endif
      else do_clear();
      check_state($sformatf("rand%0d", it));
    end

    @(negedge clk);
    chk("wrap_count", wrap_seen, m_wraps);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
